// File: rtl/clock_ctrl_pkg.sv
// Shared encodings and default widths for the processor clock-step controller.
package clock_ctrl_pkg;

  localparam int DEF_DIV_WIDTH  = 16;
  localparam int DEF_STEP_WIDTH = 8;

  localparam logic [1:0] MODE_HALTED = 2'd0;
  localparam logic [1:0] MODE_RUN    = 2'd1;
  localparam logic [1:0] MODE_STEP   = 2'd2;

endpackage

// File: rtl/clock_prescaler.sv
// Divided-rate tick generator. pc counts up to div_ratio and wraps; dropping
// enable parks pc at zero so the next run starts a full period from scratch.
module clock_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  output logic                 tick,
  output logic [DIV_WIDTH-1:0] pc
);

  // >= rather than == so a ratio lowered below the current count ticks
  // immediately instead of running pc all the way around.
  assign tick = (pc >= div_ratio);

  // Counter: cleared while disabled, wraps on tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pc <= '0;
    else if (!enable) pc <= '0;
    else if (tick)    pc <= '0;
    else              pc <= pc + DIV_WIDTH'(1);
  end

endmodule

// File: rtl/clock_step_controller.sv
// Processor clock-enable sequencer: free-run at a divided rate, halt, or run
// a counted number of enables and stop. Request priority on each edge is
// halt_req > cpu_halted > step_req > run_req; losers are dropped.
module clock_step_controller
  import clock_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH  = DEF_DIV_WIDTH,
  parameter int STEP_WIDTH = DEF_STEP_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_req,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic [STEP_WIDTH-1:0] step_count,
  input  logic [DIV_WIDTH-1:0]  div_ratio,
  input  logic                  cpu_halted,
  output logic                  cpu_en,
  output logic [1:0]            mode,
  output logic [STEP_WIDTH-1:0] steps_left,
  output logic                  step_done
);

  logic                  tick;
  logic                  active;
  logic                  pre_en;
  logic [DIV_WIDTH-1:0]  unused_pc;
  logic [1:0]            mode_d;
  logic [STEP_WIDTH-1:0] sl_d;
  logic [STEP_WIDTH-1:0] load_cnt;
  logic                  done_d;

  assign active   = (mode == MODE_RUN) || (mode == MODE_STEP);
  assign cpu_en   = tick & active & ~cpu_halted;
  assign load_cnt = (step_count == '0) ? STEP_WIDTH'(1) : step_count;

  // The prescaler must be cleared on the very edge that enters HALTED and must
  // still start from zero on the edge that leaves it, so gate on both the
  // current and the next mode.
  assign pre_en = active && (mode_d != MODE_HALTED);

  clock_prescaler #(.DIV_WIDTH(DIV_WIDTH)) u_pre (
    .clk       (clk),
    .reset     (reset),
    .enable    (pre_en),
    .div_ratio (div_ratio),
    .tick      (tick),
    .pc        (unused_pc)
  );

  // Next-state, step counter and completion pulse.
  always_comb begin
    mode_d = mode;
    sl_d   = steps_left;
    done_d = 1'b0;
    case (mode)
      MODE_HALTED: begin
        sl_d = '0;
        if (!halt_req && !cpu_halted) begin
          if (step_req) begin
            mode_d = MODE_STEP;
            sl_d   = load_cnt;
          end else if (run_req) begin
            mode_d = MODE_RUN;
          end
        end
      end
      MODE_RUN: begin
        sl_d = '0;
        if (halt_req || cpu_halted) begin
          mode_d = MODE_HALTED;
        end else if (step_req) begin
          mode_d = MODE_STEP;
          sl_d   = load_cnt;
        end
      end
      MODE_STEP: begin
        if (halt_req || cpu_halted) begin
          mode_d = MODE_HALTED;
          sl_d   = '0;
        end else if (step_req) begin
          // A reload beats a simultaneous final decrement; no done pulse.
          sl_d = load_cnt;
        end else if (run_req) begin
          mode_d = MODE_RUN;
          sl_d   = '0;
        end else if (cpu_en) begin
          if (steps_left == STEP_WIDTH'(1)) begin
            mode_d = MODE_HALTED;
            sl_d   = '0;
            done_d = 1'b1;
          end else begin
            sl_d = steps_left - STEP_WIDTH'(1);
          end
        end
      end
      default: begin
        mode_d = MODE_HALTED;
        sl_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any sequence without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode       <= MODE_HALTED;
      steps_left <= '0;
      step_done  <= 1'b0;
    end else begin
      mode       <= mode_d;
      steps_left <= sl_d;
      step_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_clock_step_controller.sv
// Directed scoreboard bench: each driven cycle queues the outputs expected in
// that cycle; a negedge monitor pops and compares.
module tb_clock_step_controller;
  import clock_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_req = 1'b0, halt_req = 1'b0, step_req = 1'b0, cpu_halted = 1'b0;
  logic [7:0]  step_count = '0;
  logic [15:0] div_ratio = '0;
  logic        cpu_en, step_done;
  logic [1:0]  mode;
  logic [7:0]  steps_left;

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic [7:0] sl;
    logic       done;
    string      tag;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] div_v = '0;
  logic        rst_v = 1'b0;

  localparam logic [1:0] H = MODE_HALTED;
  localparam logic [1:0] R = MODE_RUN;
  localparam logic [1:0] S = MODE_STEP;

  clock_step_controller dut (
    .clk        (clk),
    .reset      (reset),
    .run_req    (run_req),
    .halt_req   (halt_req),
    .step_req   (step_req),
    .step_count (step_count),
    .div_ratio  (div_ratio),
    .cpu_halted (cpu_halted),
    .cpu_en     (cpu_en),
    .mode       (mode),
    .steps_left (steps_left),
    .step_done  (step_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the edge and queue what should be seen.
  task automatic cyc(input logic r, input logic h, input logic s, input logic [7:0] cnt,
                     input logic ch, input logic e_en, input logic [1:0] e_mode,
                     input logic [7:0] e_sl, input logic e_done, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    reset      = rst_v;
    div_ratio  = div_v;
    run_req    = r;
    halt_req   = h;
    step_req   = s;
    step_count = cnt;
    cpu_halted = ch;
    e.en = e_en; e.mode = e_mode; e.sl = e_sl; e.done = e_done; e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_cmp++;
      if ({cpu_en, mode, steps_left, step_done} !== {mon_e.en, mon_e.mode, mon_e.sl, mon_e.done}) begin
        n_err++;
        $display("FAIL %s: got en=%0b mode=%0d sl=%0d done=%0b, want en=%0b mode=%0d sl=%0d done=%0b",
                 mon_e.tag, cpu_en, mode, steps_left, step_done,
                 mon_e.en, mon_e.mode, mon_e.sl, mon_e.done);
      end
    end
  end

  initial begin
    // Reset held, then released with no requests.
    rst_v = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,0, 0,H,0,0, "in_reset");
    rst_v = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0,0,0,0,0, 0,H,0,0, "idle");

    // div 0: run for ten enables, halt.
    div_v = 16'd0;
    cyc(1,0,0,0,0, 0,H,0,0, "run_req_d0");
    for (int i = 0; i < 9; i++) cyc(0,0,0,0,0, 1,R,0,0, "run_d0");
    cyc(0,1,0,0,0, 1,R,0,0, "halt_cycle_d0");
    cyc(0,0,0,0,0, 0,H,0,0, "halted_d0");
    cyc(0,0,0,0,0, 0,H,0,0, "halted_d0b");

    // div 3: enable every 4th cycle; drop to 1 while pc=3.
    div_v = 16'd3;
    cyc(1,0,0,0,0, 0,H,0,0, "run_req_d3");
    for (int c = 1; c <= 11; c++) cyc(0,0,0,0,0, logic'(c % 4 == 0),R,0,0, "run_d3");
    div_v = 16'd1;
    cyc(0,0,0,0,0, 1,R,0,0, "div_drop");
    for (int c = 13; c <= 16; c++) cyc(0,0,0,0,0, logic'(c % 2 == 0),R,0,0, "run_d1");
    cyc(0,1,0,0,0, 0,R,0,0, "halt_d1");
    cyc(0,0,0,0,0, 0,H,0,0, "halted_d1");

    // Step 3 at div 1, then step_count 0 behaves as 1.
    cyc(0,0,1,8'd3,0, 0,H,0,0, "step3_req");
    for (int c = 1; c <= 6; c++)
      cyc(0,0,0,0,0, logic'(c % 2 == 0),S,8'(3 - (c - 1) / 2),0, "step3");
    cyc(0,0,0,0,0, 0,H,0,1, "step3_done");
    cyc(0,0,0,0,0, 0,H,0,0, "step3_done_clr");
    cyc(0,0,1,8'd0,0, 0,H,0,0, "step0_req");
    cyc(0,0,0,0,0, 0,S,1,0, "step0_wait");
    cyc(0,0,0,0,0, 1,S,1,0, "step0_en");
    cyc(0,0,0,0,0, 0,H,0,1, "step0_done");
    cyc(0,0,0,0,0, 0,H,0,0, "step0_done_clr");

    // cpu_halted stops RUN and blocks requests until it drops.
    div_v = 16'd0;
    cyc(1,0,0,0,0, 0,H,0,0, "run_req_ch");
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,0, 1,R,0,0, "run_ch");
    cyc(0,0,0,0,1, 0,R,0,0, "cpu_halted_rise");
    cyc(0,0,0,0,1, 0,H,0,0, "cpu_halted_stop");
    cyc(1,0,0,0,1, 0,H,0,0, "run_while_halted");
    cyc(0,0,1,8'd5,1, 0,H,0,0, "step_while_halted");
    cyc(0,0,0,0,0, 0,H,0,0, "halted_ignored");
    cyc(1,0,0,0,0, 0,H,0,0, "run_resume_req");
    cyc(0,0,0,0,0, 1,R,0,0, "run_resumed");
    cyc(0,1,0,0,0, 1,R,0,0, "halt_after_resume");
    cyc(0,0,0,0,0, 0,H,0,0, "halted_after_resume");

    // Reload beats final decrement; halt beats step.
    cyc(0,0,1,8'd2,0, 0,H,0,0, "step2_req");
    cyc(0,0,0,0,0, 1,S,2,0, "step2_first");
    cyc(0,0,1,8'd4,0, 1,S,1,0, "reload_on_last");
    cyc(0,0,0,0,0, 1,S,4,0, "reloaded");
    cyc(0,1,1,8'd9,0, 1,S,3,0, "halt_beats_step");
    cyc(0,0,0,0,0, 0,H,0,0, "halt_no_done");

    // Long step aborted by reset at step 50, then a clean step after release.
    cyc(0,0,1,8'd200,0, 0,H,0,0, "step200_req");
    for (int c = 1; c <= 50; c++) cyc(0,0,0,0,0, 1,S,8'(201 - c),0, "step200");
    rst_v = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0,0,0,0,0, 0,H,0,0, "reset_mid_step");
    rst_v = 1'b1;
    cyc(0,0,0,0,0, 0,H,0,0, "reset_release");
    cyc(0,0,1,8'd2,0, 0,H,0,0, "post_rst_req");
    cyc(0,0,0,0,0, 1,S,2,0, "post_rst_s1");
    cyc(0,0,0,0,0, 1,S,1,0, "post_rst_s2");
    cyc(0,0,0,0,0, 0,H,0,1, "post_rst_done");
    cyc(0,0,0,0,0, 0,H,0,0, "post_rst_clr");

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
